// File: rtl/fft_bfly_stage.sv
// Radix-2 DIT butterfly stage: Y0 = A + BW, Y1 = A - BW, two-stage valid/ready pipe
// with optional divide-by-2 scaling, saturation, sticky overflow and frame marking.

module fft_bfly_lane #(
    parameter int DW    = 16,
    parameter int SCALE = 0,
    parameter int SUB   = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res,
    output logic          sat
);
    logic signed [DW:0] ext;

    // One guard bit holds the exact sum/difference of two DW-bit operands.
    assign ext = (SUB != 0) ? ($signed({a[DW-1], a}) - $signed({b[DW-1], b}))
                            : ($signed({a[DW-1], a}) + $signed({b[DW-1], b}));

    always_comb begin
        sat = 1'b0;
        res = ext[DW-1:0];
        if (SCALE != 0) begin
            res = ext[DW:1];
        end else if (ext[DW] != ext[DW-1]) begin
            sat = 1'b1;
            res = ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end
endmodule

module fft_bfly_stage #(
    parameter int DW          = 16,
    parameter int SCALE       = 0,
    parameter int FRAME_PAIRS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_real,
    input  logic [DW-1:0] a_imag,
    input  logic [DW-1:0] bw_real,
    input  logic [DW-1:0] bw_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y0_real,
    output logic [DW-1:0] y0_imag,
    output logic [DW-1:0] y1_real,
    output logic [DW-1:0] y1_imag,
    output logic          out_last,
    input  logic          clr_ovf,
    output logic          ovf
);
    localparam int CW = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_PAIRS - 1);

    logic                   s1_valid, s2_valid;
    logic [1:0][DW-1:0]     s1_a, s1_b;   // [0] real, [1] imag
    logic [3:0][DW-1:0]     lane_res, s2_y;
    logic [3:0]             lane_sat;
    logic [CW-1:0]          cnt;
    logic                   advance, in_xfer, out_xfer, s2_load;

    assign advance  = !s2_valid | out_ready;
    assign in_ready = !s1_valid | advance;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = s2_valid & out_ready;
    assign s2_load  = advance & s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_a     <= {a_imag, a_real};
                s1_b     <= {bw_imag, bw_real};
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Lanes 0/1 form Y0 (real/imag), lanes 2/3 form Y1.
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            fft_bfly_lane #(
                .DW   (DW),
                .SCALE(SCALE),
                .SUB  ((g >= 2) ? 1 : 0)
            ) u_lane (
                .a  (s1_a[g % 2]),
                .b  (s1_b[g % 2]),
                .res(lane_res[g]),
                .sat(lane_sat[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_y <= lane_res;
        end
    end

    // A clamp seen at load wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (s2_load && (|lane_sat)) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_xfer) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

    assign out_valid = s2_valid;
    assign out_last  = s2_valid & (cnt == LAST_CNT);
    assign y0_real   = s2_y[0];
    assign y0_imag   = s2_y[1];
    assign y1_real   = s2_y[2];
    assign y1_imag   = s2_y[3];
endmodule

// File: tb/tb_fft_bfly_stage.sv
// Scoreboard bench: an unscaled and a scaled butterfly stage share stimulus; an
// integer-arithmetic model predicts each output pair and its frame position.

module tb_fft_bfly_stage;
    localparam int DW = 16;
    localparam int FP = 4;

    typedef struct {
        logic [DW-1:0] y0r, y0i, y1r, y1i;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic clr_ovf = 1'b0;
    logic [DW-1:0] a_real = '0, a_imag = '0, bw_real = '0, bw_imag = '0;

    logic in_ready0, out_valid0, out_last0, ovf0;
    logic in_ready1, out_valid1, out_last1, ovf1;
    logic [DW-1:0] y0r0, y0i0, y1r0, y1i0;
    logic [DW-1:0] y0r1, y0i1, y1r1, y1i1;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int n0 = 0;
    int n1 = 0;

    always #5 clk = ~clk;

    fft_bfly_stage #(.DW(DW), .SCALE(0), .FRAME_PAIRS(FP)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a_real(a_real), .a_imag(a_imag), .bw_real(bw_real), .bw_imag(bw_imag),
        .out_valid(out_valid0), .out_ready(out_ready),
        .y0_real(y0r0), .y0_imag(y0i0), .y1_real(y1r0), .y1_imag(y1i0),
        .out_last(out_last0), .clr_ovf(clr_ovf), .ovf(ovf0));

    fft_bfly_stage #(.DW(DW), .SCALE(1), .FRAME_PAIRS(FP)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a_real(a_real), .a_imag(a_imag), .bw_real(bw_real), .bw_imag(bw_imag),
        .out_valid(out_valid1), .out_ready(out_ready),
        .y0_real(y0r1), .y0_imag(y0i1), .y1_real(y1r1), .y1_imag(y1i1),
        .out_last(out_last1), .clr_ovf(clr_ovf), .ovf(ovf1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Plain integer arithmetic: exact sum, then halve (floor) or clamp.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input bit sub, input bit scale);
        int x, y, s;
        x = $signed(a);
        y = $signed(b);
        s = sub ? x - y : x + y;
        if (scale) begin
            if (s < 0 && (s % 2) != 0) s = (s - 1) / 2;
            else s = s / 2;
        end else if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[DW-1:0];
    endfunction

    function automatic exp_t predict(input bit scale);
        exp_t e;
        e.y0r = model(a_real, bw_real, 1'b0, scale);
        e.y0i = model(a_imag, bw_imag, 1'b0, scale);
        e.y1r = model(a_real, bw_real, 1'b1, scale);
        e.y1i = model(a_imag, bw_imag, 1'b1, scale);
        return e;
    endfunction

    // Inputs change only at posedge+1, so negedge sees what the next edge will transfer.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready0) begin
            q0.push_back(predict(1'b0));
            q1.push_back(predict(1'b1));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            n0 = 0;
            n1 = 0;
        end else begin
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    check("dut0_unexpected_output", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("dut0_y0_real", y0r0, e.y0r);
                    check("dut0_y0_imag", y0i0, e.y0i);
                    check("dut0_y1_real", y1r0, e.y1r);
                    check("dut0_y1_imag", y1i0, e.y1i);
                    check("dut0_out_last", out_last0, (n0 % FP) == FP - 1);
                    n0++;
                end
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_output", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("dut1_y0_real", y0r1, e.y0r);
                    check("dut1_y0_imag", y0i1, e.y0i);
                    check("dut1_y1_real", y1r1, e.y1r);
                    check("dut1_y1_imag", y1i1, e.y1i);
                    check("dut1_out_last", out_last1, (n1 % FP) == FP - 1);
                    n1++;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                        input logic [DW-1:0] br, input logic [DW-1:0] bi);
        bit ok;
        int t;
        a_real = ar; a_imag = ai; bw_real = br; bw_imag = bi;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 100);
        if (!ok) check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        check("drain_timeout", (q0.size() != 0 || q1.size() != 0), 0);
    endtask

    task automatic random_pair();
        send(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    endtask

    initial begin
        bit done;
        // Reset state
        #12;
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_last", out_last0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_in_ready", in_ready0, 1);
        check("rst_y", {y0r0, y1i0}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic butterfly, with latency check
        send(16'h0100, 16'h0000, 16'h0080, 16'hFF80);
        @(negedge clk);
        check("latency_early", out_valid0, 0);
        @(negedge clk);
        check("latency_valid", out_valid0, 1);
        check("basic_y0r", y0r0, 16'h0180);
        check("basic_y0i", y0i0, 16'hFF80);
        check("basic_y1r", y1r0, 16'h0080);
        check("basic_y1i", y1i0, 16'h0080);
        check("basic_s_y0r", y0r1, 16'h00C0);
        check("basic_s_y0i", y0i1, 16'hFFC0);
        check("basic_s_y1r", y1r1, 16'h0040);
        check("basic_s_y1i", y1i1, 16'h0040);
        check("basic_ovf", ovf0, 0);
        drain();

        // Scaled rounding toward -inf
        send(16'hFFFF, 16'h0001, 16'h0000, 16'h0000);
        drain();
        check("round_hold_y0r", y0r1, 16'hFFFF);
        check("round_hold_y0i", y0i1, 16'h0000);

        // Saturation, sticky flag, clear
        send(16'h7000, 16'h8000, 16'h2000, 16'h0001);
        drain();
        check("sat_ovf", ovf0, 1);
        check("sat_scaled_no_ovf", ovf1, 0);
        check("sat_hold_y0r", y0r0, 16'h7FFF);
        check("sat_hold_y1i", y1i0, 16'h8000);
        repeat (3) @(negedge clk);
        check("ovf_sticky", ovf0, 1);
        @(posedge clk); #1;
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", ovf0, 0);

        // Clamp at the same edge as a clear: set wins
        clr_ovf = 1'b1;
        send(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("clr_vs_clamp_valid", out_valid0, 1);
        check("clr_vs_clamp_ovf", ovf0, 1);
        @(negedge clk);
        check("clr_after_clamp", ovf0, 0);
        clr_ovf = 1'b0;
        drain();

        // Fill with out_ready low: two pairs buffered, then in_ready drops
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        random_pair();
        random_pair();
        @(negedge clk);
        check("full_in_ready", in_ready0, 0);
        check("full_out_valid", out_valid0, 1);
        repeat (3) @(negedge clk);
        check("full_hold_in_ready", in_ready0, 0);
        check("full_queue", q0.size(), 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Stream 8 pairs under out_ready pattern 1,0,0,1
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) random_pair();
                done = 1'b1;
            end
            begin
                int k = 0;
                while ((!done || q0.size() != 0) && k < 400) begin
                    out_ready = (k % 4 == 0) || (k % 4 == 3);
                    @(posedge clk); #1;
                    k++;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n0, 8);

        // Random stream at full rate with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) random_pair();
                done = 1'b1;
            end
            begin
                int k = 0;
                done = 1'b0;
                while ((!done || q0.size() != 0) && k < 1000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                    k++;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-frame
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        send(16'h1234, 16'h0042, 16'h0101, 16'hFFF0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_out_last", out_last0, 0);
        check("midrst_ovf", ovf0, 0);
        check("midrst_y0r", y0r0, 0);
        check("midrst_in_ready", in_ready0, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) random_pair();
        drain();
        check("post_rst_count", n0, 4);
        check("post_rst_count_s", n1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
